// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU with iterative multiply/divide.
//
// Accepts one operation per valid/ready transfer on the input channel and
// returns a registered result over a valid/ready output channel. Opcodes
// 0000-1011 finish on the accepting edge. Opcodes 1100-1111 (mul, mulhu,
// divu, remu) take WIDTH cycles, one shift-add or shift-subtract per edge.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  input channel handshake
//   op, a, b            opcode and operands, captured on acceptance
//   out_valid, out_ready output channel handshake
//   result              registered result, stable while out_valid is held
//   busy                high while an iterative operation is stepping
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;
  logic [1:0]       iter_op;

  logic             accept;
  logic             iterative;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;
  logic [WIDTH-1:0] iter_result;

  // Handshake and status outputs are pure functions of the state register,
  // except in_ready, which lets a draining result make room for the next op
  // in the same cycle (the only input-to-output combinational path).
  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign accept    = in_valid & in_ready;
  assign iterative = op[3] & op[2];
  assign shamt     = b[SHW-1:0];

  // Single-cycle operations, evaluated on the live inputs and registered on
  // the accepting edge. Unused opcode 0000 falls to the zero default.
  always_comb begin
    alu_out = '0;
    case (op)
      4'b0001: alu_out = a + b;
      4'b0010: alu_out = a - b;
      4'b0011: alu_out = a ^ b;
      4'b0100: alu_out = a | b;
      4'b0101: alu_out = a & b;
      4'b0110: alu_out = a << shamt;
      4'b0111: alu_out = a >> shamt;
      4'b1000: alu_out = a << shamt;
      4'b1001: alu_out = $signed(a) >>> shamt;
      4'b1010: alu_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1011: alu_out = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_out = '0;
    endcase
  end

  // One iteration step. hi/lo form a double-width shift register: for mul,
  // hi accumulates the partial product and lo holds the remaining multiplier
  // bits; for div, hi is the partial remainder and lo shifts the dividend out
  // while the quotient bits shift in. Because the remainder always stays below
  // the divisor, the top bit of the difference is a clean borrow flag. A zero
  // divisor never borrows, which naturally yields all-ones and remainder a.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_shift = {hi, lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    hi_nxt    = hi;
    lo_nxt    = lo;
    if (!iter_op[1]) begin
      {hi_nxt, lo_nxt} = {mul_sum, lo[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      hi_nxt = div_diff[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_nxt = div_shift[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], 1'b0};
    end
    iter_result = iter_op[0] ? hi_nxt : lo_nxt;
  end

  // Control FSM and datapath registers. IDLE and DONE share acceptance logic
  // so a result drained with out_ready can be replaced by a new op on the same
  // edge. The result register is written only on edges that enter DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      result  <= '0;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      opnd    <= '0;
      iter_op <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (iterative) begin
              state   <= BUSY;
              count   <= CW'(WIDTH);
              hi      <= '0;
              lo      <= a;
              opnd    <= b;
              iter_op <= op[1:0];
            end else begin
              state  <= DONE;
              result <= alu_out;
            end
          end else if (state == DONE && out_ready) begin
            state <= IDLE;
          end
        end
        BUSY: begin
          hi    <= hi_nxt;
          lo    <= lo_nxt;
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            state  <= DONE;
            result <= iter_result;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq.
//
// Instantiates a WIDTH=32 and a WIDTH=8 copy sharing clock, reset, opcode,
// operands and out_ready; each copy has its own in_valid so only the selected
// one accepts. Inputs change on the falling edge, outputs are sampled there.
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_valid8;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] result;
  logic        busy;
  logic        in_ready8;
  logic        out_valid8;
  logic [7:0]  result8;
  logic        busy8;

  int tests_run;
  int tests_failed;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t sweep [15];

  alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .op        (op),
    .a         (a[7:0]),
    .b         (b[7:0]),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .result    (result8),
    .busy      (busy8)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a wait somewhere never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Present an operation to the selected instance at the current falling edge.
  task automatic applyStimulus(input bit sel8, input logic [3:0] o,
                               input logic [31:0] x, input logic [31:0] y);
    op = o;
    a  = x;
    b  = y;
    if (sel8) in_valid8 = 1'b1;
    else      in_valid  = 1'b1;
  endtask

  function automatic logic obs_valid(input bit sel8);
    return sel8 ? out_valid8 : out_valid;
  endfunction

  function automatic logic obs_busy(input bit sel8);
    return sel8 ? busy8 : busy;
  endfunction

  function automatic logic obs_ready(input bit sel8);
    return sel8 ? in_ready8 : in_ready;
  endfunction

  function automatic logic [31:0] obs_result(input bit sel8);
    return sel8 ? {24'b0, result8} : result;
  endfunction

  // Issue one iterative op, then watch latency, busy and in_ready until the
  // result appears (bounded), check it and let the instance drain to IDLE.
  task automatic runIter(input string tag, input bit sel8, input logic [3:0] o,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input int lat);
    int  k;
    int  busy_cycles;
    bit  ready_seen;
    bit  done;
    applyStimulus(sel8, o, x, y);
    @(negedge clk);
    in_valid    = 1'b0;
    in_valid8   = 1'b0;
    k           = 1;
    busy_cycles = 0;
    ready_seen  = 1'b0;
    done        = 1'b0;
    while (!done && k <= 100) begin
      if (obs_valid(sel8)) begin
        done = 1'b1;
      end else begin
        if (obs_busy(sel8))  busy_cycles++;
        if (obs_ready(sel8)) ready_seen = 1'b1;
        @(negedge clk);
        k++;
      end
    end
    checkOutput({tag, " latency"}, k - 1, lat);
    checkOutput({tag, " busy cycles"}, busy_cycles, lat);
    checkOutput({tag, " in_ready low"}, {31'b0, ready_seen}, 32'd0);
    checkOutput({tag, " result"}, obs_result(sel8), exp);
    @(negedge clk);
  endtask

  initial begin
    int  i;
    bit  valid_seen;

    sweep[0]  = '{4'h1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    sweep[1]  = '{4'h2, 32'h00000000, 32'h00000001, 32'hFFFFFFFF};
    sweep[2]  = '{4'h9, 32'h80000000, 32'h00000004, 32'hF8000000};
    sweep[3]  = '{4'h6, 32'h12345678, 32'd33,       32'h2468ACF0};
    sweep[4]  = '{4'hA, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    sweep[5]  = '{4'hB, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    sweep[6]  = '{4'hA, 32'h00000001, 32'hFFFFFFFF, 32'h00000000};
    sweep[7]  = '{4'hB, 32'h00000001, 32'hFFFFFFFF, 32'h00000001};
    sweep[8]  = '{4'h3, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
    sweep[9]  = '{4'h4, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0};
    sweep[10] = '{4'h5, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    sweep[11] = '{4'h7, 32'h80000000, 32'd31,       32'h00000001};
    sweep[12] = '{4'h7, 32'h80000000, 32'd4,        32'h08000000};
    sweep[13] = '{4'h8, 32'h00000003, 32'd4,        32'h00000030};
    sweep[14] = '{4'h0, 32'h00000005, 32'h00000005, 32'h00000000};

    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_valid8 = 1'b0;
    op        = 4'h0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;

    // Reset state while reset is held.
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset busy",      {31'b0, busy},      32'd0);
    checkOutput("reset result",    result,             32'd0);
    checkOutput("reset in_ready",  {31'b0, in_ready},  32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of divu 100/7 discards the operation.
    applyStimulus(1'b0, 4'hE, 32'd100, 32'd7);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("middiv busy", {31'b0, busy}, 32'd1);
    for (int s = 0; s < 10; s++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("middiv busy after rst",     {31'b0, busy},      32'd0);
    checkOutput("middiv in_ready after rst", {31'b0, in_ready},  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    valid_seen = 1'b0;
    for (int s = 0; s < 40; s++) begin
      @(negedge clk);
      if (out_valid) valid_seen = 1'b1;
    end
    checkOutput("middiv out_valid never", {31'b0, valid_seen}, 32'd0);
    checkOutput("middiv result",          result,              32'd0);
    checkOutput("middiv in_ready",        {31'b0, in_ready},   32'd1);

    // Back-to-back single-cycle sweep, one accept per clock.
    for (i = 0; i < 15; i++) begin
      applyStimulus(1'b0, sweep[i].op, sweep[i].a, sweep[i].b);
      @(negedge clk);
      checkOutput($sformatf("sweep%0d result", i), result, sweep[i].exp);
      checkOutput($sformatf("sweep%0d out_valid", i), {31'b0, out_valid}, 32'd1);
      checkOutput($sformatf("sweep%0d in_ready", i), {31'b0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("sweep drained out_valid", {31'b0, out_valid}, 32'd0);

    // Iterative operations, WIDTH=32.
    runIter("mul32",   1'b0, 4'hC, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32);
    runIter("mulhu32", 1'b0, 4'hD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32);
    runIter("divu32",  1'b0, 4'hE, 32'd100,      32'd7,        32'd14,       32);
    runIter("remu32",  1'b0, 4'hF, 32'd100,      32'd7,        32'd2,        32);
    runIter("divu0",   1'b0, 4'hE, 32'd1234,     32'd0,        32'hFFFFFFFF, 32);
    runIter("remu0",   1'b0, 4'hF, 32'd1234,     32'd0,        32'd1234,     32);

    // Back-pressure: add 3+4 stalls, a waiting xor 5^3 goes in when drained.
    out_ready = 1'b0;
    applyStimulus(1'b0, 4'h1, 32'd3, 32'd4);
    @(negedge clk);
    applyStimulus(1'b0, 4'h3, 32'd5, 32'd3);
    for (int s = 0; s < 5; s++) begin
      checkOutput($sformatf("bp%0d result", s),    result,             32'd7);
      checkOutput($sformatf("bp%0d out_valid", s), {31'b0, out_valid}, 32'd1);
      checkOutput($sformatf("bp%0d in_ready", s),  {31'b0, in_ready},  32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp in_ready on out_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp second result",    result,             32'd6);
    checkOutput("bp second out_valid", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    checkOutput("bp drained out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    checkOutput("bp no duplicate", {31'b0, out_valid}, 32'd0);

    // WIDTH=8 instance.
    runIter("mul8",   1'b1, 4'hC, 32'd15,   32'd17,   32'h000000FF, 8);
    runIter("mulhu8", 1'b1, 4'hD, 32'hFF,   32'hFF,   32'h000000FE, 8);
    applyStimulus(1'b1, 4'h9, 32'h80, 32'd9);
    @(negedge clk);
    in_valid8 = 1'b0;
    checkOutput("sra8 out_valid", {31'b0, out_valid8}, 32'd1);
    checkOutput("sra8 result",    {24'b0, result8},    32'h000000C0);
    @(negedge clk);
    checkOutput("sra8 drained", {31'b0, out_valid8}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
